i2s_s2p: RTL

I2S serial-to-parallel receiver, the inbound counterpart of the mixer's I2S transmitter. It is oversampled by the system clock `clock_in`. It synchronises the externally driven bit clock, LR clock and serial data, and deserialises standard-I2S frames (2 × 32-bit slots, MSB first, MSB one bit-clock after each LR transition). It presents one left/right sample pair per frame to the mixer core with a single-cycle valid strobe.

---
 rtl/i2s_pkg.sv | 14 +
 rtl/i2s_s2p_if.sv | 26 ++
 rtl/i2s_sync3.sv | 29 ++
 rtl/i2s_s2p.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: constants and lock-state encoding shared by the I2S receiver and
// the mixer's I2S transmitter. A frame is two 32-bit slots (left, then right).
package i2s_pkg;

  localparam int I2S_SLOT_BITS  = 32;
  localparam int I2S_FRAME_BITS = 64;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SEEK_L   = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/i2s_s2p_if.sv
// i2s_s2p_if: bundles the I2S serial pins and the parallel sample outputs of
// the receiver.
//   master : the I2S source / mixer side (drives pins, reads samples)
//   slave  : the receiver (reads pins, drives samples and strobes)
// bitNum must match the receiver's bitNum.
interface i2s_s2p_if #(parameter int bitNum = 16) ();

  logic              clock_bit;
  logic              clock_lr;
  logic              data_in;
  logic [bitNum-1:0] data_l;
  logic [bitNum-1:0] data_r;
  logic              data_valid;
  logic              frame_err;

  modport master (
    output clock_bit, clock_lr, data_in,
    input  data_l, data_r, data_valid, frame_err
  );

  modport slave (
    input  clock_bit, clock_lr, data_in,
    output data_l, data_r, data_valid, frame_err
  );

endinterface

// File: rtl/i2s_sync3.sv
// i2s_sync3: two-flop synchroniser followed by one history flop.
//   clock_in : sampling clock
//   reset_n  : async active-low reset
//   d        : asynchronous input
//   level    : synchronised level (second flop)
//   rise     : one-cycle pulse on a synchronised rising edge
// All I2S pins use this same block so their pipeline delays are identical.
module i2s_sync3 (
  input  logic clock_in,
  input  logic reset_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [2:0] sync_q;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], d};
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/i2s_s2p.sv
// i2s_s2p: standard-I2S serial-to-parallel receiver, oversampled by clock_in.
//   clock_in : system clock, >= 4x bit clock
//   reset_n  : async active-low reset
//   bus      : i2s_s2p_if slave (clock_bit, clock_lr, data_in in;
//              data_l, data_r, data_valid, frame_err out)
// One left/right pair is presented per frame with a one-cycle data_valid.
//
// state    | meaning
// ---------+------------------------------------------------------------
// UNLOCKED | after reset, waiting for an LR falling boundary
// SEEK_L   | frame start seen, waiting for the left slot to complete
// LOCKED   | aligned; right-slot completion may publish a pair
module i2s_s2p
  import i2s_pkg::*;
#(
  parameter int bitNum = 16
) (
  input logic      clock_in,
  input logic      reset_n,
  i2s_s2p_if.slave bus
);

  localparam logic [5:0] BIT_LIMIT = 6'(bitNum);
  localparam logic [5:0] CNT_SAT   = 6'(I2S_SLOT_BITS);

  logic bclk_level_unused;
  logic bit_ev;
  logic lr_s;
  logic lr_rise_unused;
  logic din_s;
  logic din_rise_unused;

  i2s_sync3 u_sync_bclk (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .d        (bus.clock_bit),
    .level    (bclk_level_unused),
    .rise     (bit_ev)
  );

  i2s_sync3 u_sync_lr (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .d        (bus.clock_lr),
    .level    (lr_s),
    .rise     (lr_rise_unused)
  );

  i2s_sync3 u_sync_din (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .d        (bus.data_in),
    .level    (din_s),
    .rise     (din_rise_unused)
  );

  lock_state_t       state_q, state_d;
  logic              lr_prev;
  logic              prev_valid;
  logic [5:0]        bit_cnt;
  logic [bitNum-1:0] shreg;
  logic [bitNum-1:0] left_hold;
  logic              left_ok;
  logic [bitNum-1:0] data_l_q, data_r_q;
  logic              valid_q, err_q;

  logic boundary, lr_rise, lr_fall, slot_full;
  logic valid_d, err_d;

  // The first bit event after reset has no previous LR to compare with, so
  // it can never be a boundary (avoids a phantom edge against the reset value).
  assign boundary  = bit_ev & prev_valid & (lr_s ^ lr_prev);
  assign lr_rise   = boundary & lr_s;
  assign lr_fall   = boundary & ~lr_s;
  assign slot_full = (bit_cnt >= BIT_LIMIT);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      UNLOCKED: if (lr_fall) state_d = SEEK_L;
      SEEK_L:   if (lr_rise) state_d = LOCKED;
      LOCKED:   state_d = LOCKED;
      default:  state_d = UNLOCKED;
    endcase
    valid_d = lr_fall & slot_full & left_ok & (state_q == LOCKED);
    err_d   = boundary & ~slot_full;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      lr_prev    <= 1'b0;
      prev_valid <= 1'b0;
      bit_cnt    <= 6'd0;
      shreg      <= '0;
      left_hold  <= '0;
      left_ok    <= 1'b0;
    end else if (bit_ev) begin
      lr_prev    <= lr_s;
      prev_valid <= 1'b1;
      if (boundary) begin
        // The bit on a boundary event is the previous slot's LSB: dropped.
        bit_cnt <= 6'd0;
        shreg   <= '0;
        if (lr_rise) begin
          if (slot_full) begin
            left_hold <= shreg;
            left_ok   <= 1'b1;
          end else begin
            left_ok   <= 1'b0;
          end
        end
      end else begin
        if (bit_cnt < BIT_LIMIT) begin
          shreg <= bitNum'({shreg, din_s});
        end
        if (bit_cnt != CNT_SAT) begin
          bit_cnt <= bit_cnt + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      data_l_q <= '0;
      data_r_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      if (valid_d) begin
        data_l_q <= left_hold;
        data_r_q <= shreg;
      end
    end
  end

  assign bus.data_l     = data_l_q;
  assign bus.data_r     = data_r_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = err_q;

endmodule
